// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requestor-side and memory-side bus bundle for the round-robin memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  localparam int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [LINE_WIDTH-1:0]           req_rdata;

  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [LINE_WIDTH-1:0]           mem_wdata;
  logic                            mem_resp;
  logic [LINE_WIDTH-1:0]           mem_rdata;

  logic [IDX_WIDTH-1:0]            grant_idx;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata, grant_idx
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata, grant_idx
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port round-robin arbiter onto one line-burst memory port.
// One transaction in flight: IDLE captures the winner, BUSY waits for mem_resp, DONE pulses resp.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  localparam int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [IDX_WIDTH-1:0]   last_grant;
  logic [IDX_WIDTH-1:0]   grant_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  wdata_q;
  logic                   write_q;
  logic [LINE_WIDTH-1:0]  rdata_q;

  logic [NUM_PORTS-1:0]   requesting;
  logic                   sel_found;
  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [IDX_WIDTH-1:0]   cand;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LINE_WIDTH-1:0]  sel_wdata;
  logic                   sel_write;
  logic [NUM_PORTS-1:0]   resp;

  assign requesting = bus.req_read | bus.req_write;

  // Scan starts just past the last served port, so the previous winner is checked last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
      if (!sel_found && requesting[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = bus.req_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.req_wdata[sel_idx*LINE_WIDTH +: LINE_WIDTH];
    sel_write = bus.req_write[sel_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_found) state_next = BUSY;
      BUSY:    if (bus.mem_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_WIDTH'(NUM_PORTS - 1);
      grant_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            write_q <= sel_write;
          end
        end
        BUSY: begin
          if (bus.mem_resp) rdata_q <= bus.mem_rdata;
        end
        DONE: begin
          last_grant <= grant_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp = '0;
    if (state == DONE) resp[grant_q] = 1'b1;
  end

  // Strobes decode straight from state so an async reset drops them without a clock edge.
  assign bus.mem_read    = (state == BUSY) && !write_q;
  assign bus.mem_write   = (state == BUSY) && write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.req_resp    = resp;
  assign bus.req_rdata   = rdata_q;
  assign bus.grant_idx   = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter (2-port table, 4-port round robin).
module tb_mem_port_arbiter;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_DB = {4{32'hDEADBEEF}};

  logic clk;
  logic reset_n;

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) b2 ();
  mem_port_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) b4 ();

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave)
  );
  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    bit          mresp;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_addr;
    bit          exp_wd;
    logic [1:0]  exp_resp;
    logic        exp_g;
    bit          exp_rdat;
  } vec_t;

  vec_t vt[$];
  int   n_cmp;
  int   n_err;
  int   grants;
  int   cyc;
  logic [3:0] prev_resp;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, logic [1:0] rd, logic [1:0] wr, logic [15:0] a0,
                              logic [15:0] a1, bit mr, logic erd, logic ewr, logic [15:0] ea,
                              bit ewd, logic [1:0] ers, logic eg, bit erdat);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.mresp = mr;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_addr = ea; v.exp_wd = ewd;
    v.exp_resp = ers; v.exp_g = eg; v.exp_rdat = erdat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    b2.req_read = '0; b2.req_write = '0; b2.req_address = '0; b2.req_wdata = '0;
    b2.mem_resp = 1'b0; b2.mem_rdata = '0;
    b4.req_read = '0; b4.req_write = '0; b4.req_address = '0; b4.req_wdata = '0;
    b4.mem_resp = 1'b0; b4.mem_rdata = '0;

    // single read by port 0, memory answers after 3 BUSY cycles
    vt.push_back(mk(1, 2'b01, 2'b00, 16'h1230, 16'h0000, 0, 0, 0, 16'h0000, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h1230, 16'h0000, 0, 1, 0, 16'h1230, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h1230, 16'h0000, 0, 1, 0, 16'h1230, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h1230, 16'h0000, 1, 1, 0, 16'h1230, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h1230, 16'h0000, 0, 0, 0, 16'h1230, 0, 2'b01, 0, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h1230, 16'h0000, 0, 0, 0, 16'h1230, 0, 2'b00, 0, 1));
    // simultaneous read (port 0) and write (port 1) after reset
    vt.push_back(mk(1, 2'b01, 2'b10, 16'h0010, 16'h0020, 0, 0, 0, 16'h0000, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b10, 16'h0010, 16'h0020, 1, 1, 0, 16'h0010, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b00, 2'b10, 16'h0010, 16'h0020, 0, 0, 0, 16'h0010, 0, 2'b01, 0, 1));
    vt.push_back(mk(0, 2'b00, 2'b10, 16'h0010, 16'h0020, 0, 0, 0, 16'h0010, 0, 2'b00, 0, 1));
    vt.push_back(mk(0, 2'b00, 2'b10, 16'h0010, 16'h0020, 0, 0, 1, 16'h0020, 1, 2'b00, 1, 1));
    vt.push_back(mk(0, 2'b00, 2'b10, 16'h0010, 16'h0020, 1, 0, 1, 16'h0020, 1, 2'b00, 1, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h0020, 1, 2'b10, 1, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h0020, 1, 2'b00, 1, 1));
    // read and write both set on port 1: write wins
    vt.push_back(mk(1, 2'b10, 2'b10, 16'h0000, 16'h0020, 0, 0, 0, 16'h0000, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b10, 2'b10, 16'h0000, 16'h0020, 1, 0, 1, 16'h0020, 1, 2'b00, 1, 0));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0000, 16'h0020, 0, 0, 0, 16'h0020, 1, 2'b10, 1, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0000, 16'h0020, 0, 0, 0, 16'h0020, 1, 2'b00, 1, 1));
    // spurious mem_resp in IDLE/DONE, address change after capture
    vt.push_back(mk(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h0080, 16'h0000, 0, 1, 0, 16'h0040, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b00, 16'h0080, 16'h0000, 1, 1, 0, 16'h0040, 0, 2'b00, 0, 0));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0080, 16'h0000, 1, 0, 0, 16'h0040, 0, 2'b01, 0, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0080, 16'h0000, 1, 0, 0, 16'h0040, 0, 2'b00, 0, 1));
    vt.push_back(mk(0, 2'b00, 2'b00, 16'h0080, 16'h0000, 0, 0, 0, 16'h0040, 0, 2'b00, 0, 1));

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) begin
      b2.req_read    = vt[i].rd;
      b2.req_write   = vt[i].wr;
      b2.req_address = {vt[i].a1, vt[i].a0};
      b2.req_wdata   = {LINE_DB, 128'h0};
      b2.mem_resp    = vt[i].mresp;
      b2.mem_rdata   = vt[i].mresp ? LINE_A5 : '0;
      if (vt[i].rst) begin
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("row%0d mem_read", i),    128'(b2.mem_read),    128'(vt[i].exp_rd));
      chk($sformatf("row%0d mem_write", i),   128'(b2.mem_write),   128'(vt[i].exp_wr));
      chk($sformatf("row%0d mem_address", i), 128'(b2.mem_address), 128'(vt[i].exp_addr));
      chk($sformatf("row%0d mem_wdata", i),   b2.mem_wdata,         vt[i].exp_wd ? LINE_DB : 128'h0);
      chk($sformatf("row%0d req_resp", i),    128'(b2.req_resp),    128'(vt[i].exp_resp));
      chk($sformatf("row%0d grant_idx", i),   128'(b2.grant_idx),   128'(vt[i].exp_g));
      chk($sformatf("row%0d req_rdata", i),   b2.req_rdata,         vt[i].exp_rdat ? LINE_A5 : 128'h0);
      @(posedge clk); #1;
    end

    // reset pulsed while BUSY: strobe drops asynchronously, no resp, port 0 wins next
    b2.req_read = 2'b10; b2.req_write = 2'b00; b2.req_address = {16'h0020, 16'h0050};
    b2.mem_resp = 1'b0; b2.mem_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst busy mem_read", 128'(b2.mem_read), 128'(1));
    chk("rst busy grant", 128'(b2.grant_idx), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst async mem_read", 128'(b2.mem_read), 128'(0));
    chk("rst async req_resp", 128'(b2.req_resp), 128'(0));
    b2.req_read = 2'b11;
    @(posedge clk); #1;
    chk("rst held req_resp", 128'(b2.req_resp), 128'(0));
    chk("rst held mem_read", 128'(b2.mem_read), 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst grant", 128'(b2.grant_idx), 128'(0));
    chk("post rst mem_read", 128'(b2.mem_read), 128'(1));
    chk("post rst mem_address", 128'(b2.mem_address), 128'(16'h0050));
    chk("post rst req_resp", 128'(b2.req_resp), 128'(0));

    // 4-port round robin with every port re-requesting after its resp
    b4.req_address = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    grants = 0;
    cyc = 0;
    prev_resp = '0;
    while (grants < 8 && cyc < 200) begin
      @(posedge clk); #1;
      b4.mem_resp = b4.mem_read | b4.mem_write;
      b4.req_read = ~b4.req_resp;
      @(negedge clk);
      if (b4.req_resp != 4'b0000) begin
        chk($sformatf("rr%0d req_resp", grants), 128'(b4.req_resp), 128'(4'b0001 << (grants % 4)));
        chk($sformatf("rr%0d grant_idx", grants), 128'(b4.grant_idx), 128'(grants % 4));
        chk($sformatf("rr%0d mem_address", grants), 128'(b4.mem_address), 128'((grants % 4) * 256));
        chk($sformatf("rr%0d resp width", grants), 128'(prev_resp), 128'(0));
        grants++;
      end
      prev_resp = b4.req_resp;
      cyc++;
    end
    if (grants < 8) chk("rr timeout grants", 128'(grants), 128'(8));
    @(negedge clk);
    chk("rr resp after last", 128'(b4.req_resp), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
